// File: rtl/patch_embed_if.sv
// patch_embed_if: start/done handshake plus the wide operand and result buses of the patch-embedding front end.
// Latency: none, this is a bundle of signals only.
// Backpressure: none; the sequencer owns start acceptance and signals completion with done/out_valid.
// Ports (modports):
//   master - drives start, patches_in, W_in, b_in, pos_in; observes busy, done, out_valid, out_emb.
//   slave  - the patch_embed side of the same signals.
interface patch_embed_if #(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LEN    = 8,
  parameter int PATCH_DIM  = 16,
  parameter int EMB_DIM    = 8
);
  logic                                    start;
  logic                                    busy;
  logic                                    done;
  logic                                    out_valid;
  logic [DATA_WIDTH*SEQ_LEN*PATCH_DIM-1:0] patches_in;
  logic [DATA_WIDTH*PATCH_DIM*EMB_DIM-1:0] W_in;
  logic [DATA_WIDTH*EMB_DIM-1:0]           b_in;
  logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0]   pos_in;
  logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0]   out_emb;

  modport master (
    output start, patches_in, W_in, b_in, pos_in,
    input  busy, done, out_valid, out_emb
  );

  modport slave (
    input  start, patches_in, W_in, b_in, pos_in,
    output busy, done, out_valid, out_emb
  );
endinterface

// File: rtl/patch_embed.sv
// patch_embed: out_emb(t,e) = sat((sum_k patch(t,k)*W(k,e) + b(e)<<F [+ pos(t,e)<<F]) >>> F) over one signed MAC.
// Latency: start accepted at edge N -> done during the cycle after edge N + SEQ_LEN*EMB_DIM*(PATCH_DIM+1).
// Backpressure: start is honoured only in S_IDLE; it is ignored while busy or in S_DONE; inputs must be held until done.
// Ports: clk, rst (synchronous, active-high); bus (patch_embed_if.slave): start, busy, done, out_valid,
//   patches_in, W_in, b_in, pos_in, out_emb.
// Build option: define PATCH_POS_EMB_EN to add pos_in to every result; otherwise pos_in is ignored.
module patch_embed #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int SEQ_LEN    = 8,
  parameter int PATCH_DIM  = 16,
  parameter int EMB_DIM    = 8
) (
  input  logic          clk,
  input  logic          rst,
  patch_embed_if.slave  bus
);
  localparam int ACC_W = 2*DATA_WIDTH + $clog2(PATCH_DIM) + 2;
  // One extra bit so the bias/position adds can never wrap before saturation.
  localparam int SUM_W = ACC_W + 1;
  localparam int TW    = (SEQ_LEN   > 1) ? $clog2(SEQ_LEN)   : 1;
  localparam int KW    = (PATCH_DIM > 1) ? $clog2(PATCH_DIM) : 1;
  localparam int EW    = (EMB_DIM   > 1) ? $clog2(EMB_DIM)   : 1;

  localparam logic [TW-1:0] T_LAST = TW'(SEQ_LEN - 1);
  localparam logic [KW-1:0] K_LAST = KW'(PATCH_DIM - 1);
  localparam logic [EW-1:0] E_LAST = EW'(EMB_DIM - 1);

  localparam logic signed [SUM_W-1:0] Y_MAX = SUM_W'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] Y_MIN = -Y_MAX - SUM_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

  state_t                        state;
  logic [TW-1:0]                 t;
  logic [KW-1:0]                 k;
  logic [EW-1:0]                 e;
  logic signed [ACC_W-1:0]       acc;
  logic [DATA_WIDTH-1:0]         out_q [SEQ_LEN][EMB_DIM];
  logic                          busy_q;
  logic                          done_q;
  logic                          valid_q;

  // Unpacked views of the flat operand buses so the sequencer can index by counter.
  logic signed [DATA_WIDTH-1:0]  patch_arr [SEQ_LEN][PATCH_DIM];
  logic signed [DATA_WIDTH-1:0]  w_arr     [PATCH_DIM][EMB_DIM];
  logic signed [DATA_WIDTH-1:0]  b_arr     [EMB_DIM];
  logic signed [DATA_WIDTH-1:0]  pos_arr   [SEQ_LEN][EMB_DIM];

  always_comb begin
    for (int i = 0; i < SEQ_LEN; i++)
      for (int j = 0; j < PATCH_DIM; j++)
        patch_arr[i][j] = bus.patches_in[DATA_WIDTH*(i*PATCH_DIM+j) +: DATA_WIDTH];
    for (int i = 0; i < PATCH_DIM; i++)
      for (int j = 0; j < EMB_DIM; j++)
        w_arr[i][j] = bus.W_in[DATA_WIDTH*(i*EMB_DIM+j) +: DATA_WIDTH];
    for (int j = 0; j < EMB_DIM; j++)
      b_arr[j] = bus.b_in[DATA_WIDTH*j +: DATA_WIDTH];
    for (int i = 0; i < SEQ_LEN; i++)
      for (int j = 0; j < EMB_DIM; j++)
        pos_arr[i][j] = bus.pos_in[DATA_WIDTH*(i*EMB_DIM+j) +: DATA_WIDTH];
  end

  // Single MAC: full-precision signed product, sign-extended into the accumulator.
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]        prod_ext;
  assign prod     = patch_arr[t][k] * w_arr[k][e];
  assign prod_ext = {{(ACC_W-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

  // Result path, only captured in S_WRITE: add bias (and position), floor-shift, saturate.
  logic signed [SUM_W-1:0]       acc_ext;
  logic signed [SUM_W-1:0]       bias_ext;
  logic signed [SUM_W-1:0]       pos_ext;
  logic signed [SUM_W-1:0]       sum;
  logic signed [SUM_W-1:0]       y;
  logic [DATA_WIDTH-1:0]         res;

  assign acc_ext  = {acc[ACC_W-1], acc};
  assign bias_ext = {{(SUM_W-DATA_WIDTH-FRAC_BITS){b_arr[e][DATA_WIDTH-1]}}, b_arr[e], {FRAC_BITS{1'b0}}};

`ifdef PATCH_POS_EMB_EN
  assign pos_ext  = {{(SUM_W-DATA_WIDTH-FRAC_BITS){pos_arr[t][e][DATA_WIDTH-1]}}, pos_arr[t][e], {FRAC_BITS{1'b0}}};
`else
  // Position table is present on the bus but deliberately does not reach the sum.
  logic unused_pos;
  assign unused_pos = ^{pos_arr[t][e]};
  assign pos_ext    = '0;
`endif

  assign sum = acc_ext + bias_ext + pos_ext;
  assign y   = sum >>> FRAC_BITS;

  always_comb begin
    res = y[DATA_WIDTH-1:0];
    if (y > Y_MAX)
      res = Y_MAX[DATA_WIDTH-1:0];
    else if (y < Y_MIN)
      res = Y_MIN[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      t       <= '0;
      k       <= '0;
      e       <= '0;
      acc     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < SEQ_LEN; i++)
        for (int j = 0; j < EMB_DIM; j++)
          out_q[i][j] <= '0;
    end else begin
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            t      <= '0;
            k      <= '0;
            e      <= '0;
            acc    <= '0;
            busy_q <= 1'b1;
            state  <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          if (k == K_LAST) begin
            state <= S_WRITE;
          end else begin
            k <= k + KW'(1);
          end
        end
        S_WRITE: begin
          out_q[t][e] <= res;
          acc         <= '0;
          k           <= '0;
          if (e == E_LAST) begin
            e <= '0;
            t <= (t == T_LAST) ? '0 : t + TW'(1);
          end else begin
            e <= e + EW'(1);
          end
          if (t == T_LAST && e == E_LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            state   <= S_DONE;
          end else begin
            state <= S_MAC;
          end
        end
        S_DONE: begin
          // One cycle of done, then back to idle regardless of start.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.out_emb = '0;
    for (int i = 0; i < SEQ_LEN; i++)
      for (int j = 0; j < EMB_DIM; j++)
        bus.out_emb[DATA_WIDTH*(i*EMB_DIM+j) +: DATA_WIDTH] = out_q[i][j];
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out_valid = valid_q;
endmodule
